// File: rtl/shift_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// shift_sequencer_pkg
// Shared encodings for the shift sequencer and its shift-register partner:
//   - SEL_*  : select codes driven to the ShiftRegister
//   - MODE_* : fill/shift mode codes sampled from MODE
//   - state_e: sequencer FSM state encoding
// ---------------------------------------------------------------------------
package shift_sequencer_pkg;

  // ShiftRegister select codes
  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LOAD  = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;  // Iright enters bit 0
  localparam logic [1:0] SEL_RIGHT = 2'b11;  // Ileft enters bit N-1

  // Operation modes
  localparam logic [1:0] MODE_FILL0  = 2'b00;
  localparam logic [1:0] MODE_FILL1  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;
  localparam logic [1:0] MODE_ARITH  = 2'b11;

  // Shift direction
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD   = 2'b01,
    SHIFT  = 2'b10,
    FINISH = 2'b11
  } state_e;

endpackage

// File: rtl/shift_sequencer_counter.sv
// ---------------------------------------------------------------------------
// shift_counter
// Down-counter holding the remaining shift count of the current operation.
// Ports:
//   CLK, RST    : clock and synchronous active-high reset (count -> 0)
//   load        : load load_value into the counter (has priority over dec)
//   load_value  : count to load
//   dec         : decrement by one (saturates at zero)
//   count       : current count
//   tc          : terminal-count flag, high when count == 1 (last shift)
// ---------------------------------------------------------------------------
module shift_counter #(
  parameter int CW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          tc
);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_value;
    end else if (dec && (count_reg != '0)) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
  // The cycle in which count is 1 is the final shift cycle.
  assign tc    = (count_reg == CW'(1));

endmodule

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
// Drives an external ShiftRegister through one load followed by a clamped
// number of single-bit shifts, supplying the serial fill bits from the
// latched mode and the register's current contents.
// Ports:
//   CLK, RST  : clock and synchronous active-high reset
//   START     : one-cycle request, honoured only in IDLE
//   DIR       : 0 = shift left (toward MSB), 1 = shift right
//   MODE      : 00 fill-0, 01 fill-1, 10 rotate, 11 arithmetic
//   AMOUNT    : requested shift count (clamped to N)
//   PDATA     : parallel word loaded into the register
//   REG_Q     : current register contents (fill feedback)
//   SEL       : register command (hold/load/left/right)
//   DATA_IN   : load word (latched PDATA)
//   Ileft     : serial bit entering bit N-1 on a right shift
//   Iright    : serial bit entering bit 0 on a left shift
//   BUSY      : high while an operation is in progress
//   DONE      : one-cycle completion pulse
// ---------------------------------------------------------------------------
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          DIR,
  input  logic [1:0]    MODE,
  input  logic [CW-1:0] AMOUNT,
  input  logic [N-1:0]  PDATA,
  input  logic [N-1:0]  REG_Q,
  output logic [1:0]    SEL,
  output logic [N-1:0]  DATA_IN,
  output logic          Ileft,
  output logic          Iright,
  output logic          BUSY,
  output logic          DONE
);

  state_e        state_reg;
  state_e        state_next;
  logic          dir_reg;
  logic [1:0]    mode_reg;
  logic [N-1:0]  pdata_reg;

  logic          latch;
  logic          cnt_load;
  logic          cnt_dec;
  logic [CW-1:0] count;
  logic          tc;
  logic [CW-1:0] amount_clamped;

  // Only the end bits of REG_Q feed the fill logic.
  logic          unused_reg_q;
  assign unused_reg_q = ^REG_Q;

  assign amount_clamped = (AMOUNT > CW'(N)) ? CW'(N) : AMOUNT;

  shift_counter #(
    .CW(CW)
  ) u_counter (
    .CLK       (CLK),
    .RST       (RST),
    .load      (cnt_load),
    .load_value(amount_clamped),
    .dec       (cnt_dec),
    .count     (count),
    .tc        (tc)
  );

  // State and operation registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      dir_reg   <= 1'b0;
      mode_reg  <= MODE_FILL0;
      pdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (latch) begin
        dir_reg   <= DIR;
        mode_reg  <= MODE;
        pdata_reg <= PDATA;
      end
    end
  end

  // Next-state logic; START outside IDLE is dropped, never queued.
  always_comb begin
    state_next = state_reg;
    latch      = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (START) begin
          state_next = LOAD;
          latch      = 1'b1;
          cnt_load   = 1'b1;
        end
      end
      LOAD: begin
        state_next = (count != '0) ? SHIFT : FINISH;
      end
      SHIFT: begin
        cnt_dec = 1'b1;
        if (tc) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Register command and status outputs
  always_comb begin
    SEL  = SEL_HOLD;
    BUSY = 1'b1;
    DONE = 1'b0;
    unique case (state_reg)
      IDLE:    BUSY = 1'b0;
      LOAD:    SEL  = SEL_LOAD;
      SHIFT:   SEL  = (dir_reg == DIR_RIGHT) ? SEL_RIGHT : SEL_LEFT;
      FINISH:  DONE = 1'b1;
      default: BUSY = 1'b0;
    endcase
  end

  // Serial fill bits. Only the input consumed by the current shift
  // direction is driven; the other stays 0, and both are 0 when not shifting.
  always_comb begin
    Ileft  = 1'b0;
    Iright = 1'b0;
    if (SEL == SEL_LEFT) begin
      unique case (mode_reg)
        MODE_FILL0:  Iright = 1'b0;
        MODE_FILL1:  Iright = 1'b1;
        MODE_ROTATE: Iright = REG_Q[N-1];
        MODE_ARITH:  Iright = 1'b0;  // arithmetic left shifts in zeros
        default:     Iright = 1'b0;
      endcase
    end else if (SEL == SEL_RIGHT) begin
      unique case (mode_reg)
        MODE_FILL0:  Ileft = 1'b0;
        MODE_FILL1:  Ileft = 1'b1;
        MODE_ROTATE: Ileft = REG_Q[0];
        MODE_ARITH:  Ileft = REG_Q[N-1];  // sign extension
        default:     Ileft = 1'b0;
      endcase
    end
  end

  assign DATA_IN = pdata_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
// Pairs shift_sequencer (N=8) with a behavioural ShiftRegister and checks
// the final register value, DONE/BUSY timing and fill behaviour per vector,
// then covers reset abort, RST+START and ignored START sequences.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  localparam int N    = 8;
  localparam int CW   = 4;
  localparam int MAXC = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          dir;
  logic [1:0]    mode;
  logic [CW-1:0] amount;
  logic [N-1:0]  pdata;
  logic [N-1:0]  reg_q = '0;
  logic [1:0]    sel;
  logic [N-1:0]  data_in;
  logic          ileft;
  logic          iright;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.N(N), .CW(CW)) dut (
    .CLK    (clk),
    .RST    (rst),
    .START  (start),
    .DIR    (dir),
    .MODE   (mode),
    .AMOUNT (amount),
    .PDATA  (pdata),
    .REG_Q  (reg_q),
    .SEL    (sel),
    .DATA_IN(data_in),
    .Ileft  (ileft),
    .Iright (iright),
    .BUSY   (busy),
    .DONE   (done)
  );

  // Behavioural ShiftRegister
  always_ff @(posedge clk) begin
    case (sel)
      2'b01:   reg_q <= data_in;
      2'b10:   reg_q <= {reg_q[N-2:0], iright};
      2'b11:   reg_q <= {ileft, reg_q[N-1:1]};
      default: reg_q <= reg_q;
    endcase
  end

  typedef struct {
    logic [7:0] pdata;
    logic       dir;
    logic [1:0] mode;
    logic [3:0] amount;
    logic [7:0] exp_q;
    int         exp_done;    // cycle after START edge in which DONE is high
    int         exp_shifts;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Per-cycle observations of one operation
  int         done_cyc, done_cnt, busy_cnt, shift_cnt, load_cnt, load_bad, fill_bad;

  task automatic clear_obs();
    done_cyc = 0; done_cnt = 0; busy_cnt = 0; shift_cnt = 0;
    load_cnt = 0; load_bad = 0; fill_bad = 0;
  endtask

  // Sample current cycle k (called at negedge)
  task automatic observe(input int k, input logic [7:0] exp_load);
    if (done) begin
      done_cnt++;
      if (done_cyc == 0) done_cyc = k;
    end
    if (busy) busy_cnt++;
    if (sel == SEL_LEFT || sel == SEL_RIGHT) shift_cnt++;
    if (sel == SEL_LOAD) begin
      load_cnt++;
      if (data_in !== exp_load) load_bad++;
    end
    if (sel == SEL_LEFT && ileft !== 1'b0) fill_bad++;
    if (sel == SEL_RIGHT && iright !== 1'b0) fill_bad++;
    if ((sel == SEL_HOLD || sel == SEL_LOAD) && (ileft !== 1'b0 || iright !== 1'b0)) fill_bad++;
  endtask

  task automatic issue(input logic [7:0] pd, input logic d, input logic [1:0] m, input logic [3:0] a);
    @(negedge clk);
    pdata = pd; dir = d; mode = m; amount = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 2'b00, 4'd3,  8'h28, 5,  3};
    vecs[1] = '{8'hA5, 1'b1, 2'b10, 4'd4,  8'h5A, 6,  4};
    vecs[2] = '{8'h90, 1'b1, 2'b11, 4'd2,  8'hE4, 4,  2};
    vecs[3] = '{8'h3C, 1'b0, 2'b00, 4'd0,  8'h3C, 2,  0};
    vecs[4] = '{8'h00, 1'b0, 2'b01, 4'd12, 8'hFF, 10, 8};
    vecs[5] = '{8'hA5, 1'b0, 2'b10, 4'd1,  8'h4B, 3,  1};
    vecs[6] = '{8'h00, 1'b1, 2'b01, 4'd3,  8'hE0, 5,  3};
    vecs[7] = '{8'h81, 1'b0, 2'b11, 4'd2,  8'h04, 4,  2};
    vecs[8] = '{8'hFF, 1'b1, 2'b00, 4'd8,  8'h00, 10, 8};
    vecs[9] = '{8'hA5, 1'b0, 2'b10, 4'd15, 8'hA5, 10, 8};

    rst = 1'b1; start = 1'b0; dir = 1'b0; mode = 2'b00; amount = '0; pdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_sel",     32'(sel),     32'(SEL_HOLD));
    chk("rst_busy",    32'(busy),    0);
    chk("rst_done",    32'(done),    0);
    chk("rst_ileft",   32'(ileft),   0);
    chk("rst_iright",  32'(iright),  0);
    chk("rst_data_in", 32'(data_in), 0);
    chk("rst_count",   32'(dut.count), 0);
    $display("reset: sel=%0d busy=%0b done=%0b data_in=%0h", sel, busy, done, data_in);
    rst = 1'b0;

    // Table-driven operations
    for (int v = 0; v < 10; v++) begin
      issue(vecs[v].pdata, vecs[v].dir, vecs[v].mode, vecs[v].amount);
      clear_obs();
      for (int k = 1; k <= MAXC; k++) begin
        observe(k, vecs[v].pdata);
        @(negedge clk);
      end
      $display("vec %0d: pdata=%0h dir=%0b mode=%0d amt=%0d -> q=%0h done@%0d busy=%0d shifts=%0d",
               v, vecs[v].pdata, vecs[v].dir, vecs[v].mode, vecs[v].amount,
               reg_q, done_cyc, busy_cnt, shift_cnt);
      chk($sformatf("v%0d_q", v),        32'(reg_q), 32'(vecs[v].exp_q));
      chk($sformatf("v%0d_done_cyc", v), done_cyc,   vecs[v].exp_done);
      chk($sformatf("v%0d_done_cnt", v), done_cnt,   1);
      chk($sformatf("v%0d_busy_cnt", v), busy_cnt,   vecs[v].exp_done);
      chk($sformatf("v%0d_shifts", v),   shift_cnt,  vecs[v].exp_shifts);
      chk($sformatf("v%0d_loads", v),    load_cnt,   1);
      chk($sformatf("v%0d_load_data", v), load_bad,  0);
      chk($sformatf("v%0d_fill", v),     fill_bad,   0);
    end

    // Reset during the second SHIFT cycle aborts without DONE
    issue(8'hA5, 1'b0, 2'b00, 4'd3);
    clear_obs();
    for (int k = 1; k <= 3; k++) begin
      observe(k, 8'hA5);
      if (k < 3) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_sel",  32'(sel),   32'(SEL_HOLD));
    chk("abort_busy", 32'(busy),  0);
    chk("abort_q",    32'(reg_q), 32'h94);
    for (int k = 0; k < 6; k++) begin
      observe(4 + k, 8'hA5);
      @(negedge clk);
    end
    chk("abort_no_done", done_cnt, 0);
    chk("abort_q_held",  32'(reg_q), 32'h94);
    $display("abort: q=%0h done_cnt=%0d", reg_q, done_cnt);

    // RST and START in the same cycle: START discarded
    pdata = 8'h11; dir = 1'b0; mode = 2'b00; amount = 4'd2;
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 32'(busy), 0);
    @(negedge clk);
    chk("rst_start_sel",  32'(sel),  32'(SEL_HOLD));
    chk("rst_start_q",    32'(reg_q), 32'h94);
    $display("rst+start: busy=%0b sel=%0d q=%0h", busy, sel, reg_q);

    // START during SHIFT is ignored
    issue(8'hA5, 1'b0, 2'b00, 4'd3);
    clear_obs();
    for (int k = 1; k <= MAXC; k++) begin
      observe(k, 8'hA5);
      start = (k == 2);
      if (k == 2) begin pdata = 8'hFF; amount = 4'd1; end
      @(negedge clk);
    end
    start = 1'b0;
    chk("mid_start_q",        32'(reg_q), 32'h28);
    chk("mid_start_done_cyc", done_cyc,   5);
    chk("mid_start_busy_cnt", busy_cnt,   5);
    $display("start in SHIFT: q=%0h done@%0d busy=%0d", reg_q, done_cyc, busy_cnt);

    // START during FINISH is ignored
    issue(8'h3C, 1'b0, 2'b00, 4'd0);
    clear_obs();
    observe(1, 8'h3C);
    @(negedge clk);
    chk("fin_done", 32'(done), 1);
    pdata = 8'h77; amount = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("fin_start_busy", 32'(busy), 0);
    @(negedge clk);
    chk("fin_start_busy2", 32'(busy), 0);
    chk("fin_start_q",     32'(reg_q), 32'h3C);
    $display("start in FINISH: busy=%0b q=%0h", busy, reg_q);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the controlled register width in bits.
REQ-002 The block SHALL have parameter CW, default $clog2(N)+1, giving the shift-amount width.
REQ-003 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port START, input, 1, a one-cycle operation request.
REQ-006 The block SHALL have port DIR, input, 1: 0 = shift toward MSB (left), 1 = toward LSB (right).
REQ-007 The block SHALL have port MODE, input, 2: 00 fill-0, 01 fill-1, 10 rotate, 11 arithmetic.
REQ-008 The block SHALL have port AMOUNT, input, CW, the requested shift count.
REQ-009 The block SHALL have port PDATA, input, N, the parallel word to load.
REQ-010 The block SHALL have port REG_Q, input, N, the current ShiftRegister OUT, used as feedback.
REQ-011 The block SHALL have port SEL, output, 2, the ShiftRegister mode: 00 hold, 01 load, 10 left (Iright enters bit 0), 11 right (Ileft enters bit N-1).
REQ-012 The block SHALL have port DATA_IN, output, N, the load word for ShiftRegister.
REQ-013 The block SHALL have ports Ileft and Iright, output, 1 each, the serial fill bits.
REQ-014 The block SHALL have port BUSY, output, 1, high while an operation is in progress.
REQ-015 The block SHALL have port DONE, output, 1, a one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, SHIFT and FINISH.
REQ-017 START sampled high in IDLE SHALL latch DIR, MODE, PDATA and min(AMOUNT,N), and the FSM SHALL enter LOAD.
REQ-018 START SHALL be ignored in LOAD, SHIFT and FINISH, with no queuing.
REQ-019 In LOAD, SEL SHALL be 01 and DATA_IN SHALL equal the latched PDATA for exactly one cycle.
REQ-020 From LOAD, the FSM SHALL go to SHIFT if the latched count is nonzero, else to FINISH.
REQ-021 In SHIFT, SEL SHALL be 10 or 11 per the latched DIR for exactly count cycles; a down-counter decrements each cycle and the FSM enters FINISH when it reaches 1.
REQ-022 In FINISH, SEL SHALL be 00 and DONE SHALL be 1 for one cycle; the FSM then returns to IDLE.
REQ-023 In IDLE, SEL SHALL be 00 and DONE SHALL be 0.
REQ-024 BUSY SHALL be 1 in LOAD, SHIFT and FINISH, and 0 in IDLE.
REQ-025 Timing SHALL be: START at edge t gives LOAD during cycle t+1, shifts during t+2..t+1+A, and DONE during t+2+A (A = clamped count).
REQ-026 Fill SHALL be combinational from the latched mode and REG_Q:
  - fill-0: fill bit 0; fill-1: fill bit 1.
  - rotate-left: Iright = REG_Q[N-1]; rotate-right: Ileft = REG_Q[0].
  - arithmetic-right: Ileft = REG_Q[N-1]; arithmetic-left: Iright = 0.
REQ-027 The fill input not selected by the current SEL SHALL be driven 0.
REQ-028 DATA_IN SHALL hold the latched PDATA in all states; it is don't-care outside LOAD.
REQ-029 AMOUNT greater than N SHALL clamp to N; AMOUNT = 0 SHALL give load only.

Reset
REQ-030 RST high at a rising edge SHALL force IDLE, SEL=00, BUSY=0, DONE=0, Ileft=0, Iright=0, count=0 and DATA_IN=0.
REQ-031 RST asserted mid-operation SHALL abort with no DONE pulse; the register keeps its partial value, since SEL=00 holds it.
REQ-032 RST and START in the same cycle: RST SHALL win and START SHALL be discarded.

Structure
REQ-033 A shared package SHALL hold the SEL encodings (SEL_HOLD, SEL_LOAD, SEL_LEFT, SEL_RIGHT), the MODE encodings and the FSM state encoding.
REQ-034 The down-counter SHALL be one sub-module, shift_counter (load, decrement, terminal-count flag, parameter CW); the FSM and fill logic stay in shift_sequencer.

Verification (bench SHALL pair the block with ShiftRegister, N=8)
REQ-035 PDATA=8'hA5, DIR=0, MODE=00, AMOUNT=3 -> register 8'h28; DONE during t+5; BUSY high t+1..t+5.
REQ-036 PDATA=8'hA5, DIR=1, MODE=10, AMOUNT=4 -> register 8'h5A; DONE during t+6.
REQ-037 PDATA=8'h90, DIR=1, MODE=11, AMOUNT=2 -> register 8'hE4.
REQ-038 AMOUNT=0, PDATA=8'h3C -> register 8'h3C; DONE during t+2; SEL never 10 or 11.
REQ-039 PDATA=8'h00, DIR=0, MODE=01, AMOUNT=12 -> clamps to 8 shifts; register 8'hFF; DONE during t+10.
REQ-040 RST during the second SHIFT cycle of the REQ-035 stimulus -> no DONE; next cycle IDLE with SEL=00; register holds 8'h94; a START pulsed in FINISH is ignored.
